// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller for an RV32I pipeline.
// Turns a load/store from the EX/MEM register into a req/gnt/rvalid transaction,
// stalls the pipeline while the access is in flight and returns an aligned,
// sign/zero-extended load result with a one-cycle completion pulse.

module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        flush_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [31:0] load_data_o,
   output logic        load_valid_o,
   output logic        err_o,
   output logic        timeout_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Counter covers REQ and WAIT together, so one grant arriving late eats into the read budget.
   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [CW-1:0] cnt;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;
   logic [2:0]    funct3_q;
   logic          we_q;
   logic          flushed_q;
   logic [31:0]   load_data_q;
   logic          load_valid_q;
   logic          timeout_q;

   logic          req_valid;
   logic          misaligned;
   logic          illegal;
   logic          start;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;
   logic [7:0]    lbyte;
   logic [15:0]   lhalf;
   logic [31:0]   load_ext;
   logic          capture;
   logic          kill;
   logic          timeout_hit;
   logic          cnt_expired;

   // Decode the incoming request: legality, byte enables and lane-replicated store data.
   always_comb begin
      req_valid  = (mem_read_i | mem_write_i) & ~flush_i & ~reset;
      misaligned = 1'b0;
      be_d       = 4'b1111;
      wdata_d    = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            misaligned = addr_i[0];
            be_d       = 4'b0011 << {addr_i[1], 1'b0};
            wdata_d    = {2{wdata_i[15:0]}};
         end
         2'b10: misaligned = (addr_i[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      illegal = (funct3_i[1:0] == 2'b11) | (funct3_i == 3'b110) | misaligned;
      start   = (state == ST_IDLE) & req_valid & ~illegal;
   end

   // Pick the addressed byte/half out of the read word and extend it according to funct3.
   always_comb begin
      case (addr_q[1:0])
         2'b00:   lbyte = dmem_rdata_i[7:0];
         2'b01:   lbyte = dmem_rdata_i[15:8];
         2'b10:   lbyte = dmem_rdata_i[23:16];
         default: lbyte = dmem_rdata_i[31:24];
      endcase
      lhalf = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{lbyte[7]}}, lbyte};
         3'b100:  load_ext = {24'h0, lbyte};
         3'b001:  load_ext = {{16{lhalf[15]}}, lhalf};
         3'b101:  load_ext = {16'h0, lhalf};
         default: load_ext = dmem_rdata_i;
      endcase
   end

   // Next-state logic; a grant or rvalid in the last budget cycle still wins over the timeout.
   always_comb begin
      next_state  = state;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      cnt_expired = (cnt >= CNT_LAST);
      kill        = flushed_q | flush_i;
      case (state)
         ST_IDLE: if (start) next_state = ST_REQ;
         ST_REQ: begin
            if (flush_i) begin
               next_state = ST_IDLE;
            end else if (dmem_gnt_i) begin
               next_state = we_q ? ST_DONE : ST_WAIT;
            end else if (cnt_expired) begin
               next_state  = ST_DONE;
               timeout_hit = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_i) begin
               next_state = ST_DONE;
               capture    = 1'b1;
            end else if (cnt_expired) begin
               next_state  = ST_DONE;
               timeout_hit = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register and the access fields latched when a legal request is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         funct3_q  <= '0;
         we_q      <= 1'b0;
         flushed_q <= 1'b0;
         cnt       <= '0;
      end else begin
         state <= next_state;
         if (start) begin
            addr_q    <= addr_i;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            funct3_q  <= funct3_i;
            we_q      <= mem_write_i;
            flushed_q <= 1'b0;
            cnt       <= '0;
         end else begin
            if ((state == ST_REQ) || (state == ST_WAIT)) cnt <= cnt + 1'b1;
            if ((state == ST_WAIT) && flush_i) flushed_q <= 1'b1;
         end
      end
   end

   // Load result and completion pulses; a flushed or timed-out access leaves load data untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         if (capture && !kill) load_data_q <= load_ext;
         load_valid_q <= capture & ~kill & ~we_q;
         timeout_q    <= timeout_hit;
      end
   end

   assign dmem_req_o   = (state == ST_REQ) & ~flush_i;
   assign dmem_we_o    = dmem_req_o & we_q;
   assign dmem_be_o    = dmem_req_o ? be_q : 4'h0;
   assign dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
   assign dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;
   assign stall_o      = start | dmem_req_o | (state == ST_WAIT);
   assign err_o        = (state == ST_IDLE) & req_valid & illegal;
   assign load_data_o  = load_data_q;
   assign load_valid_o = load_valid_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a
// transaction-level reference model (lane arithmetic, expected cycle counts).

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_i, mem_write_i, flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   logic        dmem_req_o, dmem_we_o, stall_o, load_valid_o, err_o, timeout_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, load_data_o;

   logic        to_req, to_we, to_stall, to_lv, to_err, to_timeout;
   logic [3:0]  to_be;
   logic [31:0] to_addr, to_wdata, to_load_data;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model_last;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .reset(reset), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
      .load_data_o(load_data_o), .load_valid_o(load_valid_o), .err_o(err_o),
      .timeout_o(timeout_o)
   );

   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .dmem_req_o(to_req), .dmem_we_o(to_we), .dmem_be_o(to_be),
      .dmem_addr_o(to_addr), .dmem_wdata_o(to_wdata), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(to_stall),
      .load_data_o(to_load_data), .load_valid_o(to_lv), .err_o(to_err),
      .timeout_o(to_timeout)
   );

   // Access size in bytes by RV32I load/store name; 0 marks an encoding with no meaning.
   function automatic int sizeOf(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [3:0] modelBe(input int off, input int sz);
      logic [3:0] be;
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
      return be;
   endfunction

   function automatic logic [31:0] modelWdata(input logic [31:0] wd, input int sz);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int off, input logic [31:0] rd);
      int     sz;
      longint raw;
      sz  = sizeOf(f3);
      raw = longint'(rd) >> (8 * off);
      if (sz < 4) begin
         raw = raw & ((longint'(1) << (8 * sz)) - 1);
         if (!f3[2] && raw >= (longint'(1) << (8 * sz - 1))) raw = raw - (longint'(1) << (8 * sz));
      end
      return raw[31:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic idleInputs();
      mem_read_i    = 1'b0;
      mem_write_i   = 1'b0;
      flush_i       = 1'b0;
      funct3_i      = 3'b000;
      addr_i        = 32'h0;
      wdata_i       = 32'h0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0;
   endtask

   task automatic pulseReset();
      @(posedge clk); #1;
      reset = 1'b1;
      idleInputs();
      @(posedge clk); #1;
      reset = 1'b0;
      model_last = 32'h0;
   endtask

   // One complete access with a reactive memory: grant after gnt_dly request cycles, rvalid rv_dly cycles after grant+1.
   task automatic applyStimulus(input logic is_write, input logic both, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input int gnt_dly, input int rv_dly);
      int   sz, off, exp_req, exp_stall, exp_lv, exp_err;
      int   cyc, req_seen, stall_cnt, lv_cnt, lv_cycle, err_cnt, to_cnt, grant_cyc;
      logic legal, done;
      sz        = sizeOf(f3);
      off       = int'(a[1:0]);
      legal     = (sz != 0) && ((off % sz) == 0);
      exp_req   = legal ? gnt_dly + 1 : 0;
      exp_stall = legal ? (2 + gnt_dly + (is_write ? 0 : rv_dly + 1)) : 0;
      exp_lv    = (legal && !is_write) ? 1 : 0;
      exp_err   = legal ? 0 : 1;
      cyc = 0; req_seen = 0; stall_cnt = 0; lv_cnt = 0; lv_cycle = -1;
      err_cnt = 0; to_cnt = 0; grant_cyc = -1; done = 1'b0;

      @(posedge clk); #1;
      mem_read_i  = !is_write || both;
      mem_write_i = is_write;
      funct3_i    = f3;
      addr_i      = a;
      wdata_i     = wd;
      while (!done && cyc < 40) begin
         #1;
         dmem_gnt_i    = dmem_req_o && (req_seen == gnt_dly);
         dmem_rvalid_i = (grant_cyc >= 0) && (cyc == grant_cyc + 1 + rv_dly);
         dmem_rdata_i  = dmem_rvalid_i ? rd : $urandom;
         @(negedge clk);
         if (dmem_req_o) begin
            req_seen++;
            if (dmem_gnt_i) grant_cyc = cyc;
            checkOutput("req_addr", dmem_addr_o, a & 32'hFFFF_FFFC);
            checkOutput("req_be", 32'(dmem_be_o), 32'(modelBe(off, sz)));
            checkOutput("req_we", 32'(dmem_we_o), 32'(is_write));
            if (is_write) checkOutput("req_wdata", dmem_wdata_o, modelWdata(wd, sz));
         end
         if (stall_o) stall_cnt++;
         if (err_o) err_cnt++;
         if (timeout_o) to_cnt++;
         if (load_valid_o) begin
            lv_cnt++;
            lv_cycle = cyc;
            checkOutput("load_data", load_data_o, modelLoad(f3, off, rd));
         end
         if (!stall_o) done = 1'b1;
         cyc++;
         @(posedge clk); #1;
      end
      idleInputs();
      checkOutput("txn_bound", 32'(done), 32'd1);
      checkOutput("req_cycles", 32'(req_seen), 32'(exp_req));
      checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
      checkOutput("load_valid_count", 32'(lv_cnt), 32'(exp_lv));
      checkOutput("err_count", 32'(err_cnt), 32'(exp_err));
      checkOutput("timeout_count", 32'(to_cnt), 32'd0);
      if (exp_lv == 1) begin
         checkOutput("load_valid_cycle", 32'(lv_cycle), 32'(exp_stall));
         model_last = modelLoad(f3, off, rd);
      end
      @(negedge clk);
      checkOutput("post_req", 32'(dmem_req_o), 32'd0);
      checkOutput("post_stall", 32'(stall_o), 32'd0);
      checkOutput("post_valid", 32'(load_valid_o), 32'd0);
      checkOutput("load_hold", load_data_o, model_last);
   endtask

   task automatic flushInReq();
      @(posedge clk); #1;
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h20C;
      @(negedge clk);
      checkOutput("fr_idle_stall", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("fr_req", 32'(dmem_req_o), 32'd1);
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(negedge clk);
      checkOutput("fr_flush_req", 32'(dmem_req_o), 32'd0);
      checkOutput("fr_flush_stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      idleInputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("fr_after_req", 32'(dmem_req_o), 32'd0);
         checkOutput("fr_after_valid", 32'(load_valid_o), 32'd0);
         checkOutput("fr_after_stall", 32'(stall_o), 32'd0);
      end
      checkOutput("fr_load_hold", load_data_o, model_last);
   endtask

   task automatic flushInWait();
      @(posedge clk); #1;
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h208;
      @(negedge clk);
      checkOutput("fw_idle_stall", 32'(stall_o), 32'd1);
      @(posedge clk); #2;
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      checkOutput("fw_req", 32'(dmem_req_o), 32'd1);
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      checkOutput("fw_wait_stall", 32'(stall_o), 32'd1);
      checkOutput("fw_wait_req", 32'(dmem_req_o), 32'd0);
      @(posedge clk); #1;
      flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55AA_55AA;
      @(negedge clk);
      checkOutput("fw_rvalid_stall", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0;
      @(negedge clk);
      checkOutput("fw_done_stall", 32'(stall_o), 32'd0);
      checkOutput("fw_done_valid", 32'(load_valid_o), 32'd0);
      checkOutput("fw_load_hold", load_data_o, model_last);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      checkOutput("fw_after_req", 32'(dmem_req_o), 32'd0);
   endtask

   task automatic resetInWait();
      @(posedge clk); #1;
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
      @(posedge clk); #2;
      dmem_gnt_i = 1'b1;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_read_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
      model_last = 32'h0;
      @(negedge clk);
      checkOutput("rw_req", 32'(dmem_req_o), 32'd0);
      checkOutput("rw_we", 32'(dmem_we_o), 32'd0);
      checkOutput("rw_be", 32'(dmem_be_o), 32'd0);
      checkOutput("rw_addr", dmem_addr_o, 32'h0);
      checkOutput("rw_stall", 32'(stall_o), 32'd0);
      checkOutput("rw_load_data", load_data_o, 32'h0);
      checkOutput("rw_valid", 32'(load_valid_o), 32'd0);
      checkOutput("rw_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      checkOutput("rw_late_valid", 32'(load_valid_o), 32'd0);
      checkOutput("rw_late_data", load_data_o, 32'h0);
   endtask

   // Budget of 4 cycles with no grant: four request cycles, then a timeout pulse in the release cycle.
   task automatic timeoutCheck();
      int   req_cnt, stall_cnt, to_seen, to_cyc, lv_cnt;
      logic release_req;
      req_cnt = 0; stall_cnt = 0; to_seen = 0; to_cyc = -1; lv_cnt = 0; release_req = 1'b0;
      pulseReset();
      @(posedge clk); #1;
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (to_req) req_cnt++;
         if (to_stall) stall_cnt++;
         if (to_lv) lv_cnt++;
         if (to_timeout) begin
            to_seen++;
            to_cyc = cyc;
            checkOutput("to_pulse_req", 32'(to_req), 32'd0);
            checkOutput("to_pulse_stall", 32'(to_stall), 32'd0);
         end
         if (!to_stall) release_req = 1'b1;
         @(posedge clk); #1;
         if (release_req) mem_read_i = 1'b0;
      end
      checkOutput("to_req_cycles", 32'(req_cnt), 32'd4);
      checkOutput("to_stall_cycles", 32'(stall_cnt), 32'd5);
      checkOutput("to_pulses", 32'(to_seen), 32'd1);
      checkOutput("to_pulse_cycle", 32'(to_cyc), 32'd5);
      checkOutput("to_valid", 32'(lv_cnt), 32'd0);
      checkOutput("to_load_data", to_load_data, 32'h0);
      pulseReset();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        iw, both;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      reset = 1'b1;
      idleInputs();
      model_last = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req", 32'(dmem_req_o), 32'd0);
      checkOutput("rst_we", 32'(dmem_we_o), 32'd0);
      checkOutput("rst_be", 32'(dmem_be_o), 32'd0);
      checkOutput("rst_addr", dmem_addr_o, 32'h0);
      checkOutput("rst_wdata", dmem_wdata_o, 32'h0);
      checkOutput("rst_stall", 32'(stall_o), 32'd0);
      checkOutput("rst_load_data", load_data_o, 32'h0);
      checkOutput("rst_valid", 32'(load_valid_o), 32'd0);
      checkOutput("rst_err", 32'(err_o), 32'd0);
      checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("[TB] directed accesses");
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 0, 0);
      checkOutput("lb_value", load_data_o, 32'hFFFF_FF80);
      applyStimulus(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 0, 0);
      checkOutput("lbu_value", load_data_o, 32'h0000_0080);
      applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0, 0);
      applyStimulus(1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFF_FFFF, 0, 0);
      checkOutput("lh_err_hold", load_data_o, 32'h0000_0080);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFE_F00D, 3, 1);
      applyStimulus(1'b0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0);
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h206, 32'h0, 32'h0, 0, 0);
      applyStimulus(1'b1, 1'b1, 3'b000, 32'h011, 32'h0000_00A5, 32'h0, 1, 0);
      applyStimulus(1'b0, 1'b0, 3'b101, 32'h402, 32'h0, 32'h9876_1234, 2, 3);

      $display("[TB] flush, reset and timeout cases");
      flushInReq();
      flushInWait();
      resetInWait();
      timeoutCheck();

      $display("[TB] randomized accesses");
      for (int i = 0; i < 40; i++) begin
         iw   = 1'($urandom_range(0, 1));
         both = iw && ($urandom_range(0, 3) == 0);
         f3   = 3'($urandom_range(0, 7));
         a    = $urandom;
         wd   = $urandom;
         rd   = $urandom;
         applyStimulus(iw, both, f3, a, wd, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
